// File: rtl/adc5g_snap_capture.sv
// adc5g_snap_capture: snapshot capture buffer behind the ADC5G gray-to-binary stage.
// On arm (and optionally an external trigger) DEPTH consecutive valid sample words
// are converted and written to an internal RAM. The words are then streamed out in
// order over a valid/ready port. Any full-scale sample seen while writing sets ovr.
//
// Readout handshake: a word moves on a rising edge where dout_valid && dout_ready.
// Once dout_valid is high, dout, dout_valid and dout_last stay stable until that
// transfer happens. dout_ready has no effect while dout_valid is low.
module adc5g_snap_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLES    = 4,
    parameter int DEPTH_LOG2 = 6,
    parameter int TWOS_COMP  = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [SAMPLES*DATA_WIDTH-1:0]   din,
    input  logic                            din_valid,
    input  logic                            arm,
    input  logic                            trig_mode,
    input  logic                            trig,
    output logic                            busy,
    output logic                            done,
    output logic                            ovr,
    output logic [SAMPLES*DATA_WIDTH-1:0]   dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            dout_last,
    output logic [1:0]                      state_dbg
);

    localparam int W     = SAMPLES * DATA_WIDTH;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_PTR = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [W-1:0]           mem [DEPTH];
    logic [W-1:0]           ram_q;
    logic                   ram_last;
    logic                   rd_pend;

    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2-1:0]  wr_addr;
    logic                   rd_all;

    logic [W-1:0]           skid_data;
    logic                   skid_valid;
    logic                   skid_last;

    logic [W-1:0]           conv_word;
    logic [DATA_WIDTH-1:0]  smp;
    logic                   in_ovr;
    logic                   arm_ok;
    logic                   trig_ok;
    logic                   cap_wr;
    logic                   cap_last;
    logic                   wr_en;
    logic                   xfer;
    logic                   last_xfer;
    logic [1:0]             occ;
    logic                   rd_issue;

    // Per-sample MSB inversion and full-scale detection on the raw input word.
    always_comb begin
        conv_word = din;
        in_ovr    = 1'b0;
        smp       = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            smp = din[i*DATA_WIDTH +: DATA_WIDTH];
            if (smp == '0 || smp == '1) begin
                in_ovr = 1'b1;
            end
            if (TWOS_COMP != 0) begin
                conv_word[i*DATA_WIDTH + DATA_WIDTH - 1] = ~din[i*DATA_WIDTH + DATA_WIDTH - 1];
            end
        end
    end

    // Event decodes shared by the FSM and the datapath.
    always_comb begin
        arm_ok    = (state == IDLE) && arm;
        trig_ok   = (state == ARMED) && din_valid && (!trig_mode || trig);
        cap_wr    = (state == CAPTURE) && din_valid;
        cap_last  = cap_wr && (wr_ptr == LAST_PTR);
        wr_en     = trig_ok || cap_wr;
        wr_addr   = trig_ok ? '0 : wr_ptr;
        xfer      = dout_valid && dout_ready;
        last_xfer = xfer && dout_last;
        // Words held or in flight after this edge; a new read is issued only if it
        // is guaranteed a slot in the output or skid register when it lands.
        occ       = 2'(dout_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(xfer);
        rd_issue  = (state == READOUT) && !rd_all && (occ < 2'd2);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm_ok)    state_next = ARMED;
            ARMED:   if (trig_ok)   state_next = CAPTURE;
            CAPTURE: if (cap_last)  state_next = READOUT;
            READOUT: if (last_xfer) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign busy      = (state == ARMED) || (state == CAPTURE);
    assign state_dbg = state;

    // Write pointer and the done/ovr status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            done   <= 1'b0;
            ovr    <= 1'b0;
        end else if (arm_ok) begin
            wr_ptr <= '0;
            done   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (trig_ok) begin
                wr_ptr <= DEPTH_LOG2'(1);
            end else if (cap_wr) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (cap_last) begin
                done <= 1'b1;
            end
            if (wr_en && in_ovr) begin
                ovr <= 1'b1;
            end
        end
    end

    // Capture RAM: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= conv_word;
        end
        if (rd_issue) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Read address sequencing and tracking of the word currently in the RAM output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            rd_all   <= 1'b0;
            rd_pend  <= 1'b0;
            ram_last <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (arm_ok) begin
                rd_ptr <= '0;
                rd_all <= 1'b0;
            end else if (rd_issue) begin
                rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                ram_last <= (rd_ptr == LAST_PTR);
                if (rd_ptr == LAST_PTR) begin
                    rd_all <= 1'b1;
                end
            end
        end
    end

    // Output register plus skid register so reads keep flowing at one word per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
        end else if (!dout_valid || xfer) begin
            if (skid_valid) begin
                dout       <= skid_data;
                dout_last  <= skid_last;
                dout_valid <= 1'b1;
                if (rd_pend) begin
                    skid_data <= ram_q;
                    skid_last <= ram_last;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                dout       <= ram_q;
                dout_last  <= ram_last;
                dout_valid <= 1'b1;
            end else begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end else if (rd_pend) begin
            skid_data  <= ram_q;
            skid_last  <= ram_last;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc5g_snap_capture.sv
// Directed bench for adc5g_snap_capture with an expected-word queue filled at capture
// time and drained by a readout monitor on the falling edge.
module tb_adc5g_snap_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] din;
    logic        din_valid;
    logic        arm;
    logic        trig_mode;
    logic        trig;
    logic        busy;
    logic        done;
    logic        ovr;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic [1:0]  state_dbg;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];
    int          rx_idx = 0;
    bit          stall_prev = 0;
    logic [31:0] held_dout;
    logic        held_last;
    bit          exp_ovr;

    adc5g_snap_capture #(
        .DATA_WIDTH (8),
        .SAMPLES    (4),
        .DEPTH_LOG2 (6),
        .TWOS_COMP  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig       (trig),
        .busy       (busy),
        .done       (done),
        .ovr        (ovr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .state_dbg  (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle of input drive, leaving pulse inputs low afterwards.
    task automatic drive(input logic [31:0] d, input logic v, input logic t, input logic a);
        din = d; din_valid = v; trig = t; arm = a;
        @(posedge clk); #1;
        din_valid = 1'b0; trig = 1'b0; arm = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int sel, input int k);
        case (sel)
            0:       return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            1:       return {4{8'(k+1)}};
            2:       return $urandom();
            default: return 32'hC0DE0000 | 32'(k);
        endcase
    endfunction

    function automatic bit has_ovr(input logic [31:0] d);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = d[8*i +: 8];
            if (b == 8'h00 || b == 8'hFF) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; din = '0; din_valid = 1'b0; arm = 1'b0; trig = 1'b0;
        trig_mode = 1'b0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_state", state_dbg, 0);
        reset_n = 1'b1;
    endtask

    task automatic arm_capture(input logic mode);
        trig_mode = mode;
        rx_idx = 0;
        exp_ovr = 0;
        drive('0, 1'b0, 1'b0, 1'b1);
        chk("arm_state", state_dbg, 1);
        chk("arm_busy", busy, 1);
        chk("arm_done", done, 0);
        chk("arm_ovr", ovr, 0);
    endtask

    // Drive words k0..k1-1 of a pattern, optionally with idle cycles between them.
    task automatic cap_words(input int sel, input int k0, input int k1, input bit gap, input int arm_at);
        int          k;
        int          cyc;
        logic        v;
        logic        a;
        logic [31:0] d;
        k = k0;
        cyc = 0;
        while (k < k1) begin
            v = gap ? (cyc % 2 == 0) : 1'b1;
            d = v ? pat(sel, k) : $urandom();
            a = v && (k == arm_at);
            if (v) begin
                exp_q.push_back(d ^ 32'h80808080);
                if (has_ovr(d)) exp_ovr = 1;
                k++;
            end
            drive(d, v, 1'b0, a);
            if (a) begin
                chk("arm_in_capture_state", state_dbg, 2);
                chk("arm_in_capture_busy", busy, 1);
            end
            cyc++;
        end
    endtask

    task automatic check_capture_end();
        chk("cap_done", done, 1);
        chk("cap_busy", busy, 0);
        chk("cap_state", state_dbg, 3);
        chk("cap_ovr", ovr, 32'(exp_ovr));
    endtask

    task automatic wait_readout(input bit bp, input bit hold_arm);
        int cyc;
        arm = hold_arm;
        for (cyc = 0; cyc < 3000 && rx_idx < 64; cyc++) begin
            dout_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
            @(posedge clk); #1;
        end
        chk("readout_complete", rx_idx, 64);
        arm = 1'b0;
        dout_ready = 1'b1;
        chk("end_state", state_dbg, 0);
        chk("end_dout_valid", dout_valid, 0);
        chk("end_dout_last", dout_last, 0);
        chk("end_done", done, 1);
        chk("end_ovr", ovr, 32'(exp_ovr));
        chk("end_queue_empty", exp_q.size(), 0);
    endtask

    // Readout monitor: the handshake seen here is the one the next rising edge takes.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_dout", dout, held_dout);
                chk("hold_last", dout_last, held_last);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", dout, 32'hxxxxxxxx);
                end else begin
                    chk("dout", dout, exp_q.pop_front());
                end
                chk("dout_last", dout_last, 32'(rx_idx == 63));
                rx_idx++;
            end
            stall_prev = dout_valid && !dout_ready;
            held_dout  = dout;
            held_last  = dout_last;
        end
    end

    initial begin
        // Reset and immediate-mode ramp capture.
        do_reset();
        dout_ready = 1'b1;
        arm_capture(1'b0);
        cap_words(0, 0, 64, 1'b0, -1);
        check_capture_end();
        chk("ramp_ovr_set", ovr, 1);
        drive('0, 1'b0, 1'b0, 1'b0);
        chk("latency_cycle1_valid", dout_valid, 0);
        drive('0, 1'b0, 1'b0, 1'b0);
        chk("latency_cycle2_valid", dout_valid, 1);
        chk("ramp_word0", dout, 32'h83828180);
        wait_readout(1'b0, 1'b0);

        // Triggered mode: trig without valid and valid without trig are both ignored.
        arm_capture(1'b1);
        drive(32'h00FF00FF, 1'b0, 1'b1, 1'b0);
        chk("trig_no_valid_state", state_dbg, 1);
        drive(32'h12345678, 1'b1, 1'b0, 1'b0);
        chk("valid_no_trig_state", state_dbg, 1);
        exp_q.push_back(32'h25252525);
        drive(32'hA5A5A5A5, 1'b1, 1'b1, 1'b0);
        chk("trig_state", state_dbg, 2);
        cap_words(1, 1, 64, 1'b0, -1);
        check_capture_end();
        chk("trig_ovr_clear", ovr, 0);
        wait_readout(1'b0, 1'b0);

        // Gapped input with arm during capture, then arm held through readout.
        arm_capture(1'b0);
        cap_words(2, 0, 64, 1'b1, 10);
        check_capture_end();
        wait_readout(1'b0, 1'b1);

        // Backpressure with random ready.
        arm_capture(1'b0);
        cap_words(2, 0, 64, 1'b0, -1);
        check_capture_end();
        wait_readout(1'b1, 1'b0);

        // Reset part way through a capture, then a fresh capture with a new pattern.
        arm_capture(1'b0);
        cap_words(0, 0, 20, 1'b0, -1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_state", state_dbg, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ovr", ovr, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_dout_valid", dout_valid, 0);
        chk("midrst_dout_last", dout_last, 0);
        reset_n = 1'b1;
        exp_q.delete();
        drive('0, 1'b0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0, 1'b0);
        chk("postrst_idle_valid", dout_valid, 0);
        arm_capture(1'b0);
        cap_words(3, 0, 64, 1'b0, -1);
        check_capture_end();
        wait_readout(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
